rgb_led_driver: RTL and testbench

- Clocked behavioural model of the iCE40UP5K high-current RGB LED driver, a tri-channel open-drain sink.
- Sits between the design's internal red/green/blue on/off signals and the three RGB LED package pins.
- Models the current-reference settle time, the LED enable, and the per-channel programmed sink current.
- Reports the instantaneous sink current per channel so benches can check the "reduced brightness" configuration.

---
 rtl/rgb_led_pkg.sv | 26 ++
 rtl/rgb_led_channel.sv | 45 ++++
 rtl/rgb_led_driver.sv | 76 +++++++
 tb/tb_rgb_led_driver.sv | 127 ++++++++++++
 4 files changed

// File: rtl/rgb_led_pkg.sv
// Shared constants and helpers for the RGB LED sink driver model.
// Holds the per-code-bit current steps (full and half current modes).
// Also holds the thermometer-code check and the code-to-mA conversion used by each channel.
package rgb_led_pkg;

  localparam int CURRENT_STEP_FULL_MA = 4;
  localparam int CURRENT_STEP_HALF_MA = 2;

  // A thermometer code has the form 2^k - 1, so adding one clears every set bit.
  function automatic logic is_thermometer(input logic [5:0] code);
    logic [6:0] w_inc;
    w_inc = {1'b0, code} + 7'd1;
    return (({1'b0, code} & w_inc) == 7'd0);
  endfunction

  // Each set code bit contributes one current step. The maximum is 6 * 4 = 24 mA.
  function automatic logic [4:0] code_to_ma(input logic [5:0] code, input logic mode);
    int n;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      n += int'(code[i]);
    end
    return 5'(n * (mode ? CURRENT_STEP_HALF_MA : CURRENT_STEP_FULL_MA));
  endfunction

endpackage

// File: rtl/rgb_led_channel.sv
// One open-drain sink channel. It registers the pin level and the present sink current.
// Ports: clk/reset; i_en is the shared driver gate and i_pwm is the on request.
// Outputs: o_pin is active-low (0 = sinking), and o_ma is the sink current in mA. Latency is one cycle.
import rgb_led_pkg::*;

module rgb_led_channel #(
  parameter logic [5:0] CODE = 6'b000001,
  parameter logic       MODE = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_en,
  input  logic       i_pwm,
  output logic       o_pin,
  output logic [4:0] o_ma
);

  localparam logic [4:0] LP_MA   = code_to_ma(CODE, MODE);
  // A zero code programs no current, so that channel never sinks.
  localparam logic       LP_LIVE = (CODE != 6'd0);

  if (!is_thermometer(CODE)) begin : g_bad_code
    $error("rgb_led_channel: current code %b is not a thermometer code", CODE);
  end

  logic       w_on;
  logic       r_pin;
  logic [4:0] r_ma;

  assign w_on = i_en & i_pwm & LP_LIVE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pin <= 1'b1;
      r_ma  <= 5'd0;
    end else begin
      r_pin <= ~w_on;
      r_ma  <= w_on ? LP_MA : 5'd0;
    end
  end

  assign o_pin = r_pin;
  assign o_ma  = r_ma;

endmodule

// File: rtl/rgb_led_driver.sv
// Behavioural model of the iCE40UP5K high-current RGB LED driver, a tri-channel open-drain sink.
// Ports: clk/reset (async, active-high); curren, rgbleden and rgb0..2pwm are inputs.
// Outputs: rgb0..2 are active-low pins, ready flags a settled current reference, and rgb0..2_ma report sink current. All outputs are registered.
import rgb_led_pkg::*;

module rgb_led_driver #(
  parameter int         CLOCK_HZ      = 12_000_000,
  parameter int         SETTLE_CYCLES = CLOCK_HZ / 10_000,
  parameter logic       CURRENT_MODE  = 1'b0,
  parameter logic [5:0] RGB0_CURRENT  = 6'b000001,
  parameter logic [5:0] RGB1_CURRENT  = 6'b000001,
  parameter logic [5:0] RGB2_CURRENT  = 6'b000001
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       curren,
  input  logic       rgbleden,
  input  logic       rgb0pwm,
  input  logic       rgb1pwm,
  input  logic       rgb2pwm,
  output logic       rgb0,
  output logic       rgb1,
  output logic       rgb2,
  output logic       ready,
  output logic [4:0] rgb0_ma,
  output logic [4:0] rgb1_ma,
  output logic [4:0] rgb2_ma
);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("rgb_led_driver: SETTLE_CYCLES must be at least 1");
  end

  localparam int                CNT_W     = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  LP_SETTLE = CNT_W'(SETTLE_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_ready;
  logic             w_en;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (!curren)
      w_cnt_nxt = '0;
    else if (r_cnt != LP_SETTLE)
      w_cnt_nxt = r_cnt + 1'b1;
  end

  // Ready is evaluated on the next count. It therefore rises on the same edge the count reaches SETTLE_CYCLES.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_ready <= curren && (w_cnt_nxt == LP_SETTLE);
    end
  end

  // The live curren term lets the pins release on the same edge that ready falls.
  assign w_en = r_ready & curren & rgbleden;

  rgb_led_channel #(.CODE(RGB0_CURRENT), .MODE(CURRENT_MODE)) u_ch0 (
    .clk(clk), .reset(reset), .i_en(w_en), .i_pwm(rgb0pwm), .o_pin(rgb0), .o_ma(rgb0_ma)
  );
  rgb_led_channel #(.CODE(RGB1_CURRENT), .MODE(CURRENT_MODE)) u_ch1 (
    .clk(clk), .reset(reset), .i_en(w_en), .i_pwm(rgb1pwm), .o_pin(rgb1), .o_ma(rgb1_ma)
  );
  rgb_led_channel #(.CODE(RGB2_CURRENT), .MODE(CURRENT_MODE)) u_ch2 (
    .clk(clk), .reset(reset), .i_en(w_en), .i_pwm(rgb2pwm), .o_pin(rgb2), .o_ma(rgb2_ma)
  );

  assign ready = r_ready;

endmodule

// File: tb/tb_rgb_led_driver.sv
// Directed self-checking bench for rgb_led_driver.
// Instance A uses full current with single-step codes. Instance B uses half current with codes 111111, 000000 and 000111.
// Both instances share their stimulus.
module tb_rgb_led_driver;

  logic clk = 1'b0;
  logic reset, curren, rgbleden, pwm0, pwm1, pwm2;

  logic       a_rgb0, a_rgb1, a_rgb2, a_ready;
  logic [4:0] a_ma0, a_ma1, a_ma2;
  logic       b_rgb0, b_rgb1, b_rgb2, b_ready;
  logic [4:0] b_ma0, b_ma1, b_ma2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rgb_led_driver #(
    .CLOCK_HZ(40_000), .SETTLE_CYCLES(4), .CURRENT_MODE(1'b0),
    .RGB0_CURRENT(6'b000001), .RGB1_CURRENT(6'b000001), .RGB2_CURRENT(6'b000001)
  ) dut_a (
    .clk(clk), .reset(reset), .curren(curren), .rgbleden(rgbleden),
    .rgb0pwm(pwm0), .rgb1pwm(pwm1), .rgb2pwm(pwm2),
    .rgb0(a_rgb0), .rgb1(a_rgb1), .rgb2(a_rgb2), .ready(a_ready),
    .rgb0_ma(a_ma0), .rgb1_ma(a_ma1), .rgb2_ma(a_ma2)
  );

  rgb_led_driver #(
    .CLOCK_HZ(40_000), .SETTLE_CYCLES(4), .CURRENT_MODE(1'b1),
    .RGB0_CURRENT(6'b111111), .RGB1_CURRENT(6'b000000), .RGB2_CURRENT(6'b000111)
  ) dut_b (
    .clk(clk), .reset(reset), .curren(curren), .rgbleden(rgbleden),
    .rgb0pwm(pwm0), .rgb1pwm(pwm1), .rgb2pwm(pwm2),
    .rgb0(b_rgb0), .rgb1(b_rgb1), .rgb2(b_rgb2), .ready(b_ready),
    .rgb0_ma(b_ma0), .rgb1_ma(b_ma1), .rgb2_ma(b_ma2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Checks pins, ready and mA on both instances against packed expectations.
  // Pins are given as {rgb2,rgb1,rgb0}; mA values are listed as ch0, ch1, ch2.
  task automatic chk_all(input string tag, input logic rdy,
                         input logic [2:0] a_pins, input int a0, input int a1, input int a2,
                         input logic [2:0] b_pins, input int b0, input int b1, input int b2);
    chk({tag, " a_ready"}, {31'd0, a_ready}, {31'd0, rdy});
    chk({tag, " b_ready"}, {31'd0, b_ready}, {31'd0, rdy});
    chk({tag, " a_pins"}, {29'd0, a_rgb2, a_rgb1, a_rgb0}, {29'd0, a_pins});
    chk({tag, " b_pins"}, {29'd0, b_rgb2, b_rgb1, b_rgb0}, {29'd0, b_pins});
    chk({tag, " a_ma"}, {17'd0, a_ma2, a_ma1, a_ma0}, {17'd0, 5'(a2), 5'(a1), 5'(a0)});
    chk({tag, " b_ma"}, {17'd0, b_ma2, b_ma1, b_ma0}, {17'd0, 5'(b2), 5'(b1), 5'(b0)});
  endtask

  // Advances one edge, then samples 1 ns later. Inputs change at that point too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; curren = 1'b0; rgbleden = 1'b0; pwm0 = 1'b0; pwm1 = 1'b0; pwm2 = 1'b0;
    tick(); tick();
    chk_all("reset", 1'b0, 3'b111, 0, 0, 0, 3'b111, 0, 0, 0);

    // Power-up settle: ready rises on edge 4, and the pins sink on edge 5.
    reset = 1'b0; curren = 1'b1; rgbleden = 1'b1; pwm0 = 1'b1; pwm1 = 1'b1; pwm2 = 1'b1;
    tick(); tick(); tick();
    chk_all("edge3", 1'b0, 3'b111, 0, 0, 0, 3'b111, 0, 0, 0);
    tick();
    chk_all("edge4", 1'b1, 3'b111, 0, 0, 0, 3'b111, 0, 0, 0);
    tick();
    chk_all("edge5 lit", 1'b1, 3'b000, 4, 4, 4, 3'b010, 12, 0, 6);

    // pwm2 toggling is followed one cycle later.
    pwm2 = 1'b0; tick();
    chk_all("pwm2 off", 1'b1, 3'b100, 4, 4, 0, 3'b110, 12, 0, 0);
    pwm2 = 1'b1; tick();
    chk_all("pwm2 on", 1'b1, 3'b000, 4, 4, 4, 3'b010, 12, 0, 6);

    // Dropping curren releases the pins immediately, and a full re-settle follows.
    curren = 1'b0; tick();
    chk_all("curren off", 1'b0, 3'b111, 0, 0, 0, 3'b111, 0, 0, 0);
    curren = 1'b1; tick(); tick(); tick();
    chk_all("resettle3", 1'b0, 3'b111, 0, 0, 0, 3'b111, 0, 0, 0);
    tick();
    chk_all("resettle4", 1'b1, 3'b111, 0, 0, 0, 3'b111, 0, 0, 0);
    tick();
    chk_all("resettle5", 1'b1, 3'b000, 4, 4, 4, 3'b010, 12, 0, 6);

    // rgbleden gates the pins without touching the settle state.
    rgbleden = 1'b0; tick();
    chk_all("leden off", 1'b1, 3'b111, 0, 0, 0, 3'b111, 0, 0, 0);
    rgbleden = 1'b1; tick();
    chk_all("leden on", 1'b1, 3'b000, 4, 4, 4, 3'b010, 12, 0, 6);

    // A curren fall together with a pwm rise leaves the pin released.
    pwm0 = 1'b0; tick();
    chk_all("pwm0 off", 1'b1, 3'b001, 0, 4, 4, 3'b011, 0, 0, 6);
    pwm0 = 1'b1; curren = 1'b0; tick();
    chk_all("simul", 1'b0, 3'b111, 0, 0, 0, 3'b111, 0, 0, 0);

    // Relight, then apply an asynchronous reset between edges.
    curren = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk_all("relit", 1'b1, 3'b000, 4, 4, 4, 3'b010, 12, 0, 6);
    #2 reset = 1'b1;
    #1;
    chk_all("async reset", 1'b0, 3'b111, 0, 0, 0, 3'b111, 0, 0, 0);
    tick();
    reset = 1'b0; tick(); tick(); tick();
    chk_all("post-reset3", 1'b0, 3'b111, 0, 0, 0, 3'b111, 0, 0, 0);
    tick();
    chk_all("post-reset4", 1'b1, 3'b111, 0, 0, 0, 3'b111, 0, 0, 0);
    tick();
    chk_all("post-reset5", 1'b1, 3'b000, 4, 4, 4, 3'b010, 12, 0, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
